// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared widths, FSM state encoding and initial path-metric constants for the
// Viterbi decoder frame controller and its helpers.
// ---------------------------------------------------------------------------
package viterbi_pkg;

   localparam int METRIC_W = 4;   // path-metric width
   localparam int PTR_W    = 3;   // survivor path-register write pointer width
   localparam int SYM_W    = 2;   // received code-symbol width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } seq_state_t;

   // Metrics loaded by acs_clear: state 00 starts at zero, all others at max
   // so the trellis is forced to begin in the all-zero state.
   localparam logic [METRIC_W-1:0] INIT_METRIC_ZERO = '0;
   localparam logic [METRIC_W-1:0] INIT_METRIC_MAX  = '1;

endpackage

// File: rtl/viterbi_sequencer_step_delay_line.sv
// ---------------------------------------------------------------------------
// step_delay_line
// DEPTH-stage shift register carrying {valid, pointer}; aligns ACS step
// strobes with the moment the ACS result becomes valid.
// Ports:
//   clk, rst       : clock, synchronous active-high clear of every stage
//   i_valid, i_ptr : step strobe and write pointer entering stage 0
//   o_valid, o_ptr : same pair, DEPTH cycles later
//   o_inner_busy   : a valid sits in any stage except the last, i.e. the
//                    line will still be non-empty next cycle
// ---------------------------------------------------------------------------
module step_delay_line #(
   parameter int DEPTH = 1,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic             o_valid,
   output logic [PTR_W-1:0] o_ptr,
   output logic             o_inner_busy
);

   // chain[0] is the input, chain[gi+1] is the output of stage gi
   logic [DEPTH:0]   w_v_chain;
   logic [PTR_W-1:0] w_p_chain [DEPTH+1];

   assign w_v_chain[0] = i_valid;
   assign w_p_chain[0] = i_ptr;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             r_v;
         logic [PTR_W-1:0] r_p;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_v <= 1'b0;
               r_p <= '0;
            end else begin
               r_v <= w_v_chain[gi];
               r_p <= w_p_chain[gi];
            end
         end

         assign w_v_chain[gi+1] = r_v;
         assign w_p_chain[gi+1] = r_p;
      end

      if (DEPTH > 1) begin : g_inner
         assign o_inner_busy = |w_v_chain[DEPTH-1:1];
      end else begin : g_no_inner
         assign o_inner_busy = 1'b0;
      end
   endgenerate

   assign o_valid = w_v_chain[DEPTH];
   assign o_ptr   = w_p_chain[DEPTH];

endmodule

// File: rtl/viterbi_sequencer.sv
// ---------------------------------------------------------------------------
// viterbi_sequencer
// Frame-level controller for the Viterbi datapath: accepts 2-bit symbols on a
// valid/ready handshake, issues one ACS step per symbol, appends TAIL_LEN
// zero tail steps, tracks the 3-bit survivor write pointer, delays step
// strobes by ACS_LAT for the survivor selector and inserts normalization
// cycles when the best metric reaches NORM_THRESH.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   sym_in/sym_valid/sym_last      : symbol stream in, sym_ready back
//   acs_en/acs_sym/acs_clear       : ACS step command (registered)
//   norm_en                        : subtract min_metric this cycle
//   min_metric                     : best metric, valid with sel_valid
//   sel_valid/sel_wp               : selector valid_in / write_pointer_in
//   frame_done                     : single-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module viterbi_sequencer
   import viterbi_pkg::*;
#(
   parameter int TAIL_LEN    = 2,
   parameter int NORM_THRESH = 12,
   parameter int ACS_LAT     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SYM_W-1:0]    sym_in,
   input  logic                sym_valid,
   input  logic                sym_last,
   output logic                sym_ready,
   output logic                acs_en,
   output logic [SYM_W-1:0]    acs_sym,
   output logic                acs_clear,
   output logic                norm_en,
   input  logic [METRIC_W-1:0] min_metric,
   output logic                sel_valid,
   output logic [PTR_W-1:0]    sel_wp,
   output logic                frame_done
);

   localparam int TAIL_CNT_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
   localparam logic [TAIL_CNT_W-1:0] TAIL_LAST = TAIL_CNT_W'(TAIL_LEN - 1);
   localparam logic [METRIC_W-1:0]   THRESH    = METRIC_W'(NORM_THRESH);

   seq_state_t            r_state;
   logic                  r_acs_en;
   logic                  r_acs_clear;
   logic [SYM_W-1:0]      r_acs_sym;
   logic [PTR_W-1:0]      r_acs_wp;     // pointer of the step being issued
   logic [PTR_W-1:0]      r_wp;         // pointer for the next step
   logic [TAIL_CNT_W-1:0] r_tail_cnt;
   logic                  r_norm_en;
   logic                  r_frame_done;

   logic                  w_norm_req;
   logic                  w_accept;
   logic                  w_tail_go;
   logic                  w_sel_valid;
   logic [PTR_W-1:0]      w_sel_wp;
   logic                  w_inner_busy;

   // A normalization request stalls both symbol intake and tail issue, which
   // is what keeps norm_en and acs_en mutually exclusive one cycle later.
   assign w_norm_req = w_sel_valid && (min_metric >= THRESH);
   assign sym_ready  = !rst && ((r_state == ST_IDLE) || (r_state == ST_RUN)) && !w_norm_req;
   assign w_accept   = sym_valid && sym_ready;
   assign w_tail_go  = (r_state == ST_FLUSH) && !w_norm_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_acs_en     <= 1'b0;
         r_acs_clear  <= 1'b0;
         r_acs_sym    <= '0;
         r_acs_wp     <= '0;
         r_wp         <= '0;
         r_tail_cnt   <= '0;
         r_norm_en    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_acs_en     <= 1'b0;
         r_acs_clear  <= 1'b0;
         r_norm_en    <= w_norm_req;
         r_frame_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_acs_en    <= 1'b1;
                  r_acs_clear <= 1'b1;
                  r_acs_sym   <= sym_in;
                  r_acs_wp    <= '0;
                  r_wp        <= PTR_W'(1);
                  r_tail_cnt  <= '0;
                  r_state     <= sym_last ? ST_FLUSH : ST_RUN;
               end
            end

            ST_RUN: begin
               if (w_accept) begin
                  r_acs_en  <= 1'b1;
                  r_acs_sym <= sym_in;
                  r_acs_wp  <= r_wp;
                  r_wp      <= r_wp + PTR_W'(1);
                  if (sym_last) begin
                     r_state <= ST_FLUSH;
                  end
               end
            end

            ST_FLUSH: begin
               if (w_tail_go) begin
                  r_acs_en  <= 1'b1;
                  r_acs_sym <= '0;
                  r_acs_wp  <= r_wp;
                  r_wp      <= r_wp + PTR_W'(1);
                  if (r_tail_cnt == TAIL_LAST) begin
                     r_tail_cnt <= '0;
                     r_state    <= ST_DRAIN;
                  end else begin
                     r_tail_cnt <= r_tail_cnt + TAIL_CNT_W'(1);
                  end
               end
            end

            ST_DRAIN: begin
               // frame_done is raised when the delay line will be empty on
               // the next cycle, so it lands one cycle after the final
               // sel_valid; IDLE follows once the pulse has been shown.
               if (r_frame_done) begin
                  r_state <= ST_IDLE;
               end else if (!r_acs_en && !w_inner_busy) begin
                  r_frame_done <= 1'b1;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   step_delay_line #(
      .DEPTH (ACS_LAT),
      .PTR_W (PTR_W)
   ) u_step_delay_line (
      .clk          (clk),
      .rst          (rst),
      .i_valid      (r_acs_en),
      .i_ptr        (r_acs_wp),
      .o_valid      (w_sel_valid),
      .o_ptr        (w_sel_wp),
      .o_inner_busy (w_inner_busy)
   );

   assign acs_en     = r_acs_en;
   assign acs_sym    = r_acs_sym;
   assign acs_clear  = r_acs_clear;
   assign norm_en    = r_norm_en;
   assign sel_valid  = w_sel_valid;
   assign sel_wp     = w_sel_wp;
   assign frame_done = r_frame_done;

endmodule

// File: doc/viterbi_sequencer.md
# viterbi_sequencer

Frame-level controller for the Viterbi decoder datapath. Accepts received 2-bit code symbols over a valid/ready handshake and issues one ACS step per symbol. Appends zero tail steps at frame end and tracks the 3-bit path-register write pointer. It also delays step strobes to produce the `valid_in` / `write_pointer_in` pair consumed by the survivor-path selector, and inserts metric-normalization cycles so the 4-bit path metrics never saturate.

## Interface
Parameters:
- `TAIL_LEN`, default 2: zero-input tail steps appended per frame (K=3 code).
- `NORM_THRESH`, default 12: normalize when the best metric is at or above this value (4-bit compare).
- `ACS_LAT`, default 1: cycles from `acs_en` to a valid `min_metric` / path update (1..4).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sym_in` in 2: received code symbol.
- `sym_valid` in 1: `sym_in` valid.
- `sym_last` in 1: marks the last data symbol of the frame.
- `sym_ready` out 1: symbol accepted when `sym_valid && sym_ready`.
- `acs_en` out 1: one ACS step this cycle.
- `acs_sym` out 2: symbol for this step (2'b00 during tail).
- `acs_clear` out 1: reload initial metrics (state 00 = 0, others = max); high with the first step of a frame.
- `norm_en` out 1: subtract `min_metric` from all four metrics this cycle.
- `min_metric` in 4: best metric from the ACS, valid when `sel_valid` = 1.
- `sel_valid` out 1: drives the selector's `valid_in`.
- `sel_wp` out 3: drives the selector's `write_pointer_in`.
- `frame_done` out 1: single-cycle end-of-frame pulse.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN. Reset state is IDLE.
- `norm_req = sel_valid && (min_metric >= NORM_THRESH)`. This is combinational and used only as a stall condition.
- `sym_ready = (state==IDLE || state==RUN) && !norm_req`.
- IDLE, on accept:
  - Next cycle: `acs_en`=1, `acs_clear`=1, `acs_sym` = accepted symbol.
  - Go to RUN, or to FLUSH if `sym_last`=1.
  - The write pointer is set to 0 for this step.
- RUN: each accept produces `acs_en`=1 with the registered symbol next cycle. An accept with `sym_last`=1 moves to FLUSH.
- FLUSH:
  - `sym_ready`=0.
  - Issues `TAIL_LEN` steps with `acs_sym`=00 on consecutive cycles.
  - A tail step is withheld in any cycle where `norm_req`=1; the tail counter holds.
  - After the last tail step, go to DRAIN.
- DRAIN: wait until the `sel_valid` delay line is empty. In the following cycle, pulse `frame_done` and return to IDLE.
- Normalization:
  - `norm_req` in cycle c gives `norm_en`=1 in cycle c+1.
  - `acs_en` is guaranteed 0 in c+1, because nothing was accepted or issued in c.
  - Normalization requests arising in FLUSH/DRAIN are serviced identically.
- Write pointer:
  - Internal `wp` is 3 bits; `acs_wp` = `wp` during a step, and `wp` increments after each `acs_en`.
  - Wraps 7 to 0 with no stall; the selector is trusted to consume in order.
- Delay line: an `ACS_LAT`-deep shift register of {`acs_en`, `acs_wp`} produces {`sel_valid`, `sel_wp`}.
- `acs_clear` is never asserted without `acs_en`.
- `norm_en` and `acs_en` are never high together.

## Timing
- Reset values: all outputs 0. `sym_ready` = 1 combinationally once out of reset (IDLE, no `norm_req`). State IDLE, `wp`=0, tail counter 0, delay line cleared.
- Latency:
  - Accept at cycle t gives `acs_en` at t+1.
  - It gives `sel_valid` with `sel_wp` = step pointer at t+1+`ACS_LAT`.
- Throughput: one symbol per cycle, except one bubble per normalization.
- Frame overhead: `TAIL_LEN` + `ACS_LAT` + 1 cycles from the last data step to `frame_done`. The next frame is accepted from the cycle after `frame_done`.
- Reset mid-frame: the next cycle is fully idle and in-flight `sel_valid` pulses are discarded. No `frame_done` is issued.
- `sym_valid` while `sym_ready`=0: the symbol is held by the source, and no state changes occur.

## Structure
- Shared package `viterbi_pkg`:
  - `METRIC_W`=4, `PTR_W`=3, `SYM_W`=2.
  - State encoding enum {IDLE, RUN, FLUSH, DRAIN}.
  - Initial-metric constants.
- One natural sub-module, `step_delay_line`: parameterized-depth shift register carrying {valid, pointer}, synchronous clear.
- The FSM, tail counter and pointer logic live in the top module.

## Test plan
- Frame of 3 symbols (01, 10, 11), last on third, `min_metric`=0:
  - `acs_en` on 5 cycles.
  - `acs_sym` = 01, 10, 11, 00, 00.
  - `acs_clear` only on the first.
  - `sel_wp` = 0..4.
  - `frame_done` 1 cycle after the last `sel_valid`.
- 10-symbol frame: `sel_wp` sequence is 0..7, 0..3, showing 7 to 0 wrap with no bubble.
- `min_metric`=12 on the third `sel_valid`:
  - `sym_ready`=0 that cycle and `norm_en`=1 next cycle, with `acs_en`=0.
  - Stream resumes with no lost or duplicated symbol.
- `min_metric`=12 during FLUSH: the tail step is delayed one cycle, and exactly `TAIL_LEN` tail steps are still issued.
- `rst` asserted mid-RUN with 2 steps in flight:
  - All outputs 0 next cycle and no `sel_valid` or `frame_done` afterward.
  - Next frame starts with `acs_clear` and `wp`=0.
- Single-symbol frame (`sym_last` on first) and back-to-back frames: IDLE goes straight to FLUSH, and the second frame is accepted the cycle after `frame_done`.
